out_channel_checker: RTL and testbench

Downstream consumer of the program-execution core's out channel. Buffers every word the core writes to its output area in a small FIFO, compares the words in order against an expected-output table, and raises `finished`/`success` once the core signals end of program and the FIFO has drained. It replaces the per-test inline `success = outMem[..] == ..` checks with one reusable, back-pressured stage between the core and the FPGA status pins.

---
 rtl/out_channel_checker_pkg.sv | 17 +
 rtl/out_channel_checker_if.sv | 24 ++
 rtl/out_channel_checker_fifo.sv | 72 +++++++
 rtl/out_channel_checker.sv | 140 ++++++++++++++
 tb/tb_out_channel_checker.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/out_channel_checker_pkg.sv
// Shared definitions for the out-channel checker: FSM state encoding and
// the width of count-style fields (word counters, mismatch index).
package out_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A count field must hold 0..n inclusive, hence one bit more than an index.
    function automatic int count_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/out_channel_checker_if.sv
// Out-channel bundle between the execution core (master) and the checker
// (slave): valid/ready word handshake plus the end-of-program level.
interface out_channel_checker_if #(
    parameter int MemoryElementWidth = 12
);
    logic                          out_valid;
    logic [MemoryElementWidth-1:0] out_data;
    logic                          out_ready;
    logic                          prog_done;

    modport master (
        output out_valid,
        output out_data,
        output prog_done,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  prog_done,
        output out_ready
    );
endinterface

// File: rtl/out_channel_checker_fifo.sv
// Small synchronous first-word-fall-through FIFO buffering out-channel words.
// Full and empty are registered so upstream ready never depends on a
// same-cycle pop.
module out_fifo #(
    parameter int Width = 12,
    parameter int Depth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW  = $clog2(Depth);
    localparam int PW1 = PW + 1;
    localparam logic [PW:0] DEPTH_C = PW1'(Depth);

    logic [Width-1:0] mem_reg [Depth];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic [PW:0]      count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             do_push;
    logic             do_pop;

    // Requests against a full/empty buffer are dropped rather than corrupting it.
    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers, occupancy and the registered full/empty flags.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_C);
            empty_reg <= (count_next == '0);
        end
    end

    // Word storage; contents need no reset because empty gates every read.
    always_ff @(posedge clock) begin
        if (do_push) mem_reg[wr_ptr_reg] <= wdata;
    end

    assign rdata = mem_reg[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/out_channel_checker.sv
// Out-channel checker: buffers the core's out words, compares them in order
// against a preloaded expected table and reports pass/fail once the program
// has ended and the buffer has drained.
module out_channel_checker
    import out_check_pkg::*;
#(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 16,
    parameter int FifoDepth          = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    out_channel_checker_if.slave             oc,
    input  logic                             exp_we,
    input  logic [$clog2(NOut)-1:0]          exp_addr,
    input  logic [MemoryElementWidth-1:0]    exp_data,
    input  logic [count_width(NOut)-1:0]     exp_count,
    input  logic                             start,
    output logic                             finished,
    output logic                             success,
    output logic [count_width(NOut)-1:0]     mismatch_index
);
    localparam int AW = $clog2(NOut);
    localparam int CW = count_width(NOut);
    localparam logic [CW-1:0] NOUT_C    = CW'(NOut);
    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    state_t                        state_reg;
    state_t                        state_next;
    logic [CW-1:0]                 exp_count_reg;
    logic [CW-1:0]                 rx_count_reg;
    logic [CW-1:0]                 mismatch_index_reg;
    logic                          fail_reg;
    logic [MemoryElementWidth-1:0] table_mem [NOut];

    logic                          ready_int;
    logic                          fifo_push;
    logic                          fifo_pop;
    logic                          fifo_flush;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [MemoryElementWidth-1:0] fifo_rdata;
    logic [MemoryElementWidth-1:0] table_word;
    logic                          expected_slot;
    logic                          in_table;
    logic                          checking;

    // Ready depends only on registered state and the registered full flag.
    assign ready_int    = (state_reg == RUN) && !fifo_full;
    assign oc.out_ready = ready_int;
    assign fifo_push    = oc.out_valid && ready_int;
    assign checking     = (state_reg == RUN) || (state_reg == DRAIN);
    assign fifo_pop     = checking && !fifo_empty;
    assign fifo_flush   = (state_reg == IDLE) && start;

    // The table is read combinationally at the current word position so a
    // word is judged in the same cycle it leaves the FIFO.
    assign table_word    = table_mem[rx_count_reg[AW-1:0]];
    assign expected_slot = rx_count_reg < exp_count_reg;
    assign in_table      = rx_count_reg < NOUT_C;

    out_fifo #(
        .Width (MemoryElementWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (oc.out_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state selection for IDLE -> RUN -> DRAIN -> DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)        state_next = RUN;
            RUN:     if (oc.prog_done) state_next = DRAIN;
            DRAIN:   if (fifo_empty)   state_next = DONE;
            DONE:                      state_next = DONE;
            default:                   state_next = IDLE;
        endcase
    end

    // State, counters and the sticky first-failure record.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg          <= IDLE;
            exp_count_reg      <= '0;
            rx_count_reg       <= '0;
            fail_reg           <= 1'b0;
            mismatch_index_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (state_reg == IDLE && start) begin
                exp_count_reg      <= exp_count;
                rx_count_reg       <= '0;
                fail_reg           <= 1'b0;
                mismatch_index_reg <= '0;
            end

            if (fifo_pop) begin
                if (rx_count_reg != COUNT_MAX) rx_count_reg <= rx_count_reg + 1'b1;
                // Only the first failure is recorded. Surplus words are a
                // count error; an expected slot past the table end can never
                // match and is reported at its own position.
                if (!fail_reg) begin
                    if (!expected_slot) begin
                        fail_reg           <= 1'b1;
                        mismatch_index_reg <= exp_count_reg;
                    end else if (!in_table || fifo_rdata != table_word) begin
                        fail_reg           <= 1'b1;
                        mismatch_index_reg <= rx_count_reg;
                    end
                end
            end

            // A short program is only detectable once everything has drained.
            if (state_reg == DRAIN && fifo_empty && !fail_reg
                && rx_count_reg != exp_count_reg) begin
                mismatch_index_reg <= exp_count_reg;
            end
        end
    end

    // Expected table: writable only while idle, never cleared by reset.
    always_ff @(posedge clock) begin
        if (state_reg == IDLE && exp_we) table_mem[exp_addr] <= exp_data;
    end

    assign finished       = (state_reg == DONE);
    assign success        = finished && !fail_reg && (rx_count_reg == exp_count_reg);
    assign mismatch_index = mismatch_index_reg;

endmodule

// File: tb/tb_out_channel_checker.sv
// Bench for out_channel_checker: directed scenarios plus randomized runs,
// judged by a list-level reference model of the expected-output rules.
module tb_out_channel_checker;
    import out_check_pkg::*;

    localparam int W  = 12;
    localparam int N  = 16;
    localparam int D  = 4;
    localparam int AW = $clog2(N);
    localparam int CW = count_width(N);

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    out_channel_checker_if #(.MemoryElementWidth(W)) oc ();

    logic          exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [W-1:0]  exp_data = '0;
    logic [CW-1:0] exp_count = '0;
    logic          start = 1'b0;
    logic          finished;
    logic          success;
    logic [CW-1:0] mismatch_index;

    out_channel_checker #(
        .MemoryElementWidth (W),
        .NOut               (N),
        .FifoDepth          (D)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .oc             (oc.slave),
        .exp_we         (exp_we),
        .exp_addr       (exp_addr),
        .exp_data       (exp_data),
        .exp_count      (exp_count),
        .start          (start),
        .finished       (finished),
        .success        (success),
        .mismatch_index (mismatch_index)
    );

    int errors = 0;
    int checks = 0;

    logic [W-1:0] tbl [N];
    int           tbl_count;
    logic [W-1:0] words [40];
    int           n_words;
    int           done_cycles;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Reference: walk the emitted word list against the table and count.
    task automatic model(output bit ok, output int idx);
        bit failed = 0;
        idx = 0;
        for (int i = 0; i < n_words; i++) begin
            if (!failed) begin
                if (i >= tbl_count) begin
                    failed = 1; idx = tbl_count;
                end else if (words[i] != tbl[i]) begin
                    failed = 1; idx = i;
                end
            end
        end
        if (!failed && n_words != tbl_count) idx = tbl_count;
        ok = !failed && (n_words == tbl_count);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; oc.out_valid = 1'b0; oc.out_data = '0; oc.prog_done = 1'b0;
        start = 1'b0; exp_we = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic load_table();
        for (int i = 0; i < N; i++) begin
            exp_we = 1'b1; exp_addr = AW'(i); exp_data = tbl[i];
            @(negedge clock);
        end
        exp_we = 1'b0;
    endtask

    task automatic pulse_start();
        exp_count = CW'(tbl_count);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Offer each word until the DUT takes it; idle gaps of 0..gap_max cycles.
    task automatic stream(input int gap_max);
        for (int i = 0; i < n_words; i++) begin
            int gap = $urandom_range(0, gap_max);
            int budget = 50;
            for (int g = 0; g < gap; g++) begin
                oc.out_valid = 1'b0;
                @(negedge clock);
            end
            oc.out_valid = 1'b1;
            oc.out_data = words[i];
            while (!oc.out_ready && budget > 0) begin
                @(negedge clock);
                budget--;
            end
            if (budget == 0) begin
                check_value("ready_timeout", 32'(oc.out_ready), 32'd1);
                break;
            end
            @(negedge clock);
        end
        oc.out_valid = 1'b0;
        check_value("no_early_finish", 32'(finished), 32'd0);
        check_value("no_early_success", 32'(success), 32'd0);
    endtask

    task automatic finish_and_check(input string tag);
        bit ok;
        int idx;
        oc.prog_done = 1'b1;
        done_cycles = 0;
        while (!finished && done_cycles < 20) begin
            @(negedge clock);
            done_cycles++;
        end
        model(ok, idx);
        check_value({tag, "_finished"}, 32'(finished), 32'd1);
        check_value({tag, "_success"}, 32'(success), 32'(ok));
        if (!ok) check_value({tag, "_index"}, 32'(mismatch_index), 32'(idx));
    endtask

    initial begin
        bit ok_unused;
        oc.out_valid = 1'b0; oc.out_data = '0; oc.prog_done = 1'b0;

        // Reset state.
        do_reset();
        check_value("rst_ready", 32'(oc.out_ready), 32'd0);
        check_value("rst_finished", 32'(finished), 32'd0);
        check_value("rst_success", 32'(success), 32'd0);
        check_value("rst_index", 32'(mismatch_index), 32'd0);

        // Single word, quick completion.
        for (int i = 0; i < N; i++) tbl[i] = '0;
        tbl[0] = 12'd2; tbl_count = 1;
        words[0] = 12'd2; n_words = 1;
        load_table(); pulse_start(); stream(0);
        finish_and_check("single");
        check_value("single_latency_ok", 32'(done_cycles <= 3), 32'd1);

        // Mid-sequence mismatch.
        do_reset();
        tbl[0] = 12'd5; tbl[1] = 12'd7; tbl[2] = 12'd9; tbl_count = 3;
        words[0] = 12'd5; words[1] = 12'd8; words[2] = 12'd9; n_words = 3;
        load_table(); pulse_start(); stream(1);
        finish_and_check("mismatch");

        // Short count.
        do_reset();
        tbl[0] = 12'd4; tbl[1] = 12'd4; tbl_count = 2;
        words[0] = 12'd4; n_words = 1;
        load_table(); pulse_start(); stream(0);
        finish_and_check("short");

        // Long count (table retained across reset).
        do_reset();
        words[0] = 12'd4; words[1] = 12'd4; words[2] = 12'd4; n_words = 3;
        pulse_start(); stream(0);
        finish_and_check("long");

        // Valid held high for 8 back-to-back words.
        do_reset();
        for (int i = 0; i < 8; i++) begin tbl[i] = W'(i + 1); words[i] = W'(i + 1); end
        tbl_count = 8; n_words = 8;
        load_table(); pulse_start(); stream(0);
        finish_and_check("burst");

        // Reset in the middle of a run, then rerun on the retained table.
        do_reset();
        for (int i = 0; i < 4; i++) begin tbl[i] = W'(i + 1); words[i] = W'(i + 1); end
        tbl_count = 4; n_words = 2;
        load_table(); pulse_start(); stream(0);
        do_reset();
        check_value("midrst_ready", 32'(oc.out_ready), 32'd0);
        check_value("midrst_finished", 32'(finished), 32'd0);
        n_words = 4;
        pulse_start(); stream(0);
        finish_and_check("rerun");

        // Table write while running is ignored; start in DONE is ignored.
        do_reset();
        tbl[0] = 12'd3; tbl[1] = 12'd6; tbl_count = 2;
        words[0] = 12'd3; words[1] = 12'd6; n_words = 2;
        load_table(); pulse_start();
        exp_we = 1'b1; exp_addr = '0; exp_data = 12'hFFF;
        @(negedge clock);
        exp_we = 1'b0;
        stream(0);
        finish_and_check("guard");
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_value("done_start_finished", 32'(finished), 32'd1);
        check_value("done_start_success", 32'(success), 32'd1);

        // Randomized runs: random table, count, length and corruptions.
        for (int it = 0; it < 12; it++) begin
            int lo;
            do_reset();
            for (int i = 0; i < N; i++) tbl[i] = W'($urandom_range(0, 4095));
            tbl_count = $urandom_range(1, N);
            lo = (tbl_count > 1) ? tbl_count - 1 : 0;
            n_words = $urandom_range(lo, tbl_count + 1);
            for (int i = 0; i < n_words; i++) begin
                words[i] = (i < N) ? tbl[i] : W'($urandom_range(0, 4095));
                if ($urandom_range(0, 7) == 0) words[i] = words[i] ^ W'($urandom_range(1, 4095));
            end
            load_table(); pulse_start(); stream(2);
            finish_and_check($sformatf("rand%0d", it));
        end

        ok_unused = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
